square_decode: RTL and testbench
================================

SQUARE_DECODE -- requirements
Module: square_decode

Interface
REQ-001 Parameter THRESH, default 12'd559: period in Q ticks; below it a cycle is a 1 bit, at or above it a 0 bit.
REQ-002 Parameter MIN_PERIOD, default 12'd150: cycles shorter than this are glitches.
REQ-003 Parameter TIMEOUT, default 12'd2047: Q ticks without an accepted edge before carrier loss.
REQ-004 Parameter SYNC_BYTE, default 8'h3C: byte-alignment pattern.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 Q  input  1  CPU Q clock, sampled in clk domain; each rising edge is one timebase tick.
REQ-008 enable  input  1  motor/decoder enable; low forces IDLE.
REQ-009 din  input  1  cassette comparator output, asynchronous.
REQ-010 byte_out  output  8  last received byte, LSB-first assembled.
REQ-011 byte_valid  output  1  one-clk pulse when byte_out updates.
REQ-012 synced  output  1  high while in RECV.
REQ-013 carrier_err  output  1  one-clk pulse on timeout while in HUNT or RECV.

Function
REQ-014 din SHALL pass a 2-flop synchronizer; an accepted edge is a 0->1 transition of the synchronized signal.
REQ-015 Tick SHALL be Q high with previous-clk Q low (registered Q sample).
REQ-016 12-bit period counter SHALL increment per tick, saturating at 4095.
REQ-017 On an edge with count >= MIN_PERIOD: count SHALL load 0 (a coincident tick is dropped) and one bit SHALL be produced, 1 if count < THRESH else 0.
REQ-018 On an edge with count < MIN_PERIOD: edge ignored, counter keeps running, no bit.
REQ-019 First edge after reset, IDLE exit or timeout SHALL only restart the counter, producing no bit.
REQ-020 States: IDLE, HUNT, RECV; enable low in any state -> IDLE next clk; IDLE with enable high -> HUNT.
REQ-021 HUNT: each bit shifts into 8-bit sr as {bit, sr[7:1]}; if the new sr equals SYNC_BYTE -> RECV, bit count 0; sync byte not output.
REQ-022 RECV: each bit shifts in, bit count increments; on 8th bit byte_out SHALL load the new sr and byte_valid pulse the following clk, count wraps to 0.
REQ-023 Count reaching TIMEOUT in HUNT or RECV without an edge that clk: carrier_err pulse, state -> HUNT, partial byte discarded; no further carrier_err until an accepted edge occurs.
REQ-024 Edge and timeout in the same clk: edge wins, no carrier_err.
REQ-025 IDLE: counter, sr, bit count cleared; byte_out holds its value; no pulses.
REQ-026 Latency: byte_valid SHALL assert 4 clk after the final din rising edge at the pin (2 sync, 1 detect/classify, 1 output).

Reset
REQ-027 reset_n low SHALL immediately force IDLE, byte_out 8'h00, byte_valid 0, synced 0, carrier_err 0, counter/sr/bit count 0, synchronizer flops 0.
REQ-028 Reset mid-byte SHALL discard the partial byte with no pulse.

Configuration
REQ-029 Macro SQUARE_DECODE_GLITCH_FILTER_EN defined: synchronized din passes a 3-sample majority filter clocked on ticks before edge detection; latency grows by up to 2 ticks, period measurement unaffected in steady state.
REQ-030 Macro undefined: no filter; edge detection uses synchronizer output directly.

Verification
REQ-031 Leader of 0x55 (1 = 372-tick cycle, 0 = 745-tick cycle) then 0x3C then 0xA7 -> synced rises after 0x3C; one byte_valid with byte_out=8'hA7.
REQ-032 Bytes 0x3C,0x00,0xFF -> byte_valid twice, 0x00 then 0xFF; bit boundaries at periods 558 (1) and 559 (0) verified.
REQ-033 Inject 50-tick pulse mid-byte -> ignored, byte still correct.
REQ-034 Stop din after 3 bits in RECV -> carrier_err single pulse 2047 ticks after last edge, synced=0, no byte_valid.
REQ-035 Drop enable mid-byte, re-raise, resend sync+0x12 -> only 0x12 delivered; byte_out held during IDLE.
REQ-036 Assert reset_n low mid-byte -> all outputs zero at once; recovery with sync+0x5A yields 8'h5A.

Source files
------------

// File: rtl/square_decode.sv
// Purpose : cassette square-wave decoder; period-classifies din cycles into bits, aligns on SYNC_BYTE, assembles bytes LSB-first.
// Latency : byte_valid 4 clk after the final din rising edge at the pin (2 sync, 1 detect/classify, 1 output).
// Backpress: none; byte_valid is a one-clk pulse and byte_out holds until the next byte.
//
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   Q                 CPU Q clock; each rising edge (seen in clk domain) is one timebase tick
//   enable            decoder enable; low forces IDLE
//   din               asynchronous comparator output
//   byte_out          last received byte
//   byte_valid        one-clk pulse when byte_out updates
//   synced            high while byte-aligned (RECV)
//   carrier_err       one-clk pulse when no accepted edge arrives within TIMEOUT ticks
//
// Optional feature: define SQUARE_DECODE_GLITCH_FILTER_EN to insert a 3-sample,
// tick-clocked majority filter between the synchronizer and the edge detector.
module square_decode #(
    parameter logic [11:0] THRESH     = 12'd559,
    parameter logic [11:0] MIN_PERIOD = 12'd150,
    parameter logic [11:0] TIMEOUT    = 12'd2047,
    parameter logic [7:0]  SYNC_BYTE  = 8'h3C
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Q,
    input  logic       enable,
    input  logic       din,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       synced,
    output logic       carrier_err
);

    typedef enum logic [1:0] {IDLE, HUNT, RECV} state_t;

    state_t      state;
    logic        din_s1, din_s2, din_d, q_d;
    logic        din_f;
    logic [11:0] cnt;
    logic        first;     // next edge only restarts the counter
    logic        armed;     // carrier_err allowed (cleared by a timeout until an accepted edge)
    logic        bit_vld, bit_val;
    logic [7:0]  sr;
    logic [2:0]  nbits;

    logic        tick, edge_det, active, edge_acc, timeout;
    logic [7:0]  sr_nxt;

    // Synchronizer and Q sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
            q_d    <= 1'b0;
        end else begin
            din_s1 <= din;
            din_s2 <= din_s1;
            q_d    <= Q;
        end
    end

    assign tick = Q & ~q_d;

`ifdef SQUARE_DECODE_GLITCH_FILTER_EN
    logic [2:0] samp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            samp <= 3'b000;
        else if (tick)
            samp <= {samp[1:0], din_s2};
    end

    assign din_f = (samp[0] & samp[1]) | (samp[1] & samp[2]) | (samp[0] & samp[2]);
`else
    assign din_f = din_s2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            din_d <= 1'b0;
        else
            din_d <= din_f;
    end

    assign edge_det = din_f & ~din_d;
    assign active   = enable && (state != IDLE);
    // The restart edge is accepted regardless of count; otherwise short cycles are glitches.
    assign edge_acc = active && edge_det && (first || (cnt >= MIN_PERIOD));
    // A coincident accepted edge suppresses the timeout.
    assign timeout  = active && armed && (cnt >= TIMEOUT) && !edge_acc;
    assign sr_nxt   = {bit_val, sr[7:1]};
    assign synced   = (state == RECV);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 12'd0;
            first       <= 1'b1;
            armed       <= 1'b1;
            bit_vld     <= 1'b0;
            bit_val     <= 1'b0;
            sr          <= 8'h00;
            nbits       <= 3'd0;
            byte_out    <= 8'h00;
            byte_valid  <= 1'b0;
            carrier_err <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            carrier_err <= 1'b0;
            bit_vld     <= 1'b0;
            if (!enable || (state == IDLE)) begin
                // IDLE clears the measurement and framing; byte_out is held.
                state <= enable ? HUNT : IDLE;
                cnt   <= 12'd0;
                first <= 1'b1;
                armed <= 1'b1;
                sr    <= 8'h00;
                nbits <= 3'd0;
            end else begin
                // Period measurement and bit classification
                if (edge_acc) begin
                    cnt     <= 12'd0;
                    first   <= 1'b0;
                    armed   <= 1'b1;
                    bit_vld <= !first;
                    bit_val <= (cnt < THRESH);
                end else if (tick && (cnt != 12'hFFF)) begin
                    cnt <= cnt + 12'd1;
                end

                // Framing; a pending bit cannot coincide with a timeout since the
                // counter was just reloaded by the edge that produced it.
                if (timeout) begin
                    carrier_err <= 1'b1;
                    state       <= HUNT;
                    sr          <= 8'h00;
                    nbits       <= 3'd0;
                    first       <= 1'b1;
                    armed       <= 1'b0;
                end else if (bit_vld) begin
                    sr <= sr_nxt;
                    case (state)
                        HUNT: begin
                            if (sr_nxt == SYNC_BYTE) begin
                                state <= RECV;
                                nbits <= 3'd0;
                            end
                        end
                        RECV: begin
                            if (nbits == 3'd7) begin
                                byte_out   <= sr_nxt;
                                byte_valid <= 1'b1;
                                nbits      <= 3'd0;
                            end else begin
                                nbits <= nbits + 3'd1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_square_decode.sv
// Purpose : randomized self-checking bench for square_decode against a bit-stream reference model.
// Latency : checks byte_valid 4 clk after the final pin edge and carrier_err timing after the last edge.
// Backpress: none; the bench drives din/Q/enable freely and only observes outputs.
module tb_square_decode;

    localparam int          THRESH = 559;
    localparam int          MIN_P  = 150;
    localparam int          TMO    = 2047;
    localparam logic [7:0]  SYNC   = 8'h3C;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       Q = 1'b0;
    logic       enable = 1'b0;
    logic       din = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid, synced, carrier_err;

    square_decode dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Q           (Q),
        .enable      (enable),
        .din         (din),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .synced      (synced),
        .carrier_err (carrier_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Q runs at half the clk rate: one tick every 2 clk.
    initial forever begin
        @(posedge clk);
        #1 Q = ~Q;
    end

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (bit-stream level) ----------------
    int         m_state;        // 0 idle, 1 hunting, 2 receiving
    bit         m_first, m_armed;
    int         m_cnt;          // ticks since the last accepted edge
    logic [7:0] m_sr;
    int         m_nb;
    logic [7:0] exp_q[$];
    int         exp_err = 0;
    int         last_edge_cyc = 0;
    logic [7:0] last_byte = 8'h00;

    task automatic model_clear(input int st);
        m_state = st;
        m_first = 1'b1;
        m_armed = 1'b1;
        m_cnt   = 0;
        m_sr    = 8'h00;
        m_nb    = 0;
    endtask

    task automatic model_bit(input logic b);
        m_sr = {b, m_sr[7:1]};
        if (m_state == 1) begin
            if (m_sr == SYNC) begin
                m_state = 2;
                m_nb    = 0;
            end
        end else if (m_state == 2) begin
            m_nb++;
            if (m_nb == 8) begin
                exp_q.push_back(m_sr);
                m_nb = 0;
            end
        end
    endtask

    // Rising edge on din, applied while Q is low so edge spacing equals tick count.
    task automatic edge_up();
        din = 1'b1;
        if (m_state != 0) begin
            if (m_first) begin
                m_first = 1'b0;
                m_cnt   = 0;
                m_armed = 1'b1;
                last_edge_cyc = cyc;
            end else if (m_cnt >= MIN_P) begin
                model_bit(m_cnt < THRESH);
                m_cnt   = 0;
                m_armed = 1'b1;
                last_edge_cyc = cyc;
            end
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n) @(negedge Q);
        if (m_state != 0) begin
            m_cnt += n;
            if (m_cnt >= TMO && m_armed) begin
                exp_err++;
                m_state = 1;
                m_first = 1'b1;
                m_armed = 1'b0;
                m_sr    = 8'h00;
                m_nb    = 0;
            end
        end
    endtask

    // One din cycle of the given length; optional short glitch pulse 50 ticks in.
    task automatic cyc_bit(input int ticks, input bit glitch);
        int h;
        edge_up();
        if (glitch) begin
            wait_q(20);
            din = 1'b0;
            wait_q(30);
            edge_up();
            wait_q(5);
            din = 1'b0;
            wait_q(ticks - 55);
        end else begin
            h = $urandom_range(ticks / 2, 10);
            wait_q(h);
            din = 1'b0;
            wait_q(ticks - h);
        end
    endtask

    // mode 0: randomized periods on both sides of the boundaries, 1: 372/745, 2: 558/559
    function automatic int period(input logic b, input int mode);
        if (mode == 1) return b ? 372 : 745;
        if (mode == 2) return b ? 558 : 559;
        return b ? $urandom_range(170, MIN_P) : $urandom_range(570, THRESH);
    endfunction

    task automatic send_byte(input logic [7:0] v, input int mode, input int glitch_bit);
        for (int i = 0; i < 8; i++)
            cyc_bit(period(v[i], mode), (i == glitch_bit));
        check_eq("synced", synced, (m_state == 2));
    endtask

    // ---------------- output monitor ----------------
    int bv_cnt = 0;
    int ce_cnt = 0;
    int ce_cyc = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (byte_valid) begin
                bv_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_byte_valid", byte_valid, 1'b0);
                end else begin
                    last_byte = exp_q.pop_front();
                    check_eq("byte_out", byte_out, last_byte);
                    check_eq("byte_latency", cyc - last_edge_cyc, 4);
                end
            end
            if (carrier_err) begin
                ce_cnt++;
                ce_cyc = cyc;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bv0, ce0;
        model_clear(0);

        // Reset state
        enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_byte_out", byte_out, 8'h00);
        check_eq("rst_byte_valid", byte_valid, 1'b0);
        check_eq("rst_synced", synced, 1'b0);
        check_eq("rst_carrier_err", carrier_err, 1'b0);
        reset_n = 1'b1;
        model_clear(1);
        wait_q(10);

        // Leader 0x55, sync, 0xA7 at 372/745-tick cycles
        bv0 = bv_cnt;
        send_byte(8'h55, 1, -1);
        send_byte(SYNC, 1, -1);
        send_byte(8'hA7, 1, -1);
        // Two more cycles: the first edge completes 0xA7, leaving a partial byte
        cyc_bit(period($urandom_range(1, 0), 0), 1'b0);
        cyc_bit(period($urandom_range(1, 0), 0), 1'b0);
        check_eq("t1_synced", synced, 1'b1);
        check_eq("t1_byte_count", bv_cnt - bv0, 1);

        // Reset mid-byte: outputs clear immediately, partial byte dropped
        reset_n = 1'b0;
        model_clear(0);
        #1;
        check_eq("midrst_byte_out", byte_out, 8'h00);
        check_eq("midrst_byte_valid", byte_valid, 1'b0);
        check_eq("midrst_synced", synced, 1'b0);
        check_eq("midrst_carrier_err", carrier_err, 1'b0);
        last_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        model_clear(1);
        wait_q(10);
        bv0 = bv_cnt;
        send_byte(SYNC, 0, -1);
        send_byte(8'h5A, 0, -1);
        cyc_bit(period($urandom_range(1, 0), 0), 1'b0);
        cyc_bit(period($urandom_range(1, 0), 0), 1'b0);
        check_eq("t6_byte_count", bv_cnt - bv0, 1);

        // Drop enable mid-byte, hold, then resend sync + 0x12
        enable = 1'b0;
        model_clear(0);
        wait_q(20);
        check_eq("idle_synced", synced, 1'b0);
        check_eq("idle_byte_out_held", byte_out, last_byte);
        enable = 1'b1;
        model_clear(1);
        wait_q(10);
        bv0 = bv_cnt;
        send_byte(SYNC, 0, -1);
        send_byte(8'h12, 0, -1);

        // Three bits in RECV then silence: single carrier_err, no byte
        for (int i = 0; i < 3; i++)
            cyc_bit(period($urandom_range(1, 0), 0), 1'b0);
        edge_up();
        wait_q(10);
        din = 1'b0;
        check_eq("t5_byte_count", bv_cnt - bv0, 1);
        bv0 = bv_cnt;
        ce0 = ce_cnt;
        wait_q(2100);
        check_eq("timeout_pulses", ce_cnt - ce0, 1);
        // 2 sync clk + TIMEOUT ticks of 2 clk + 1 output register
        check_eq("timeout_timing", ce_cyc - last_edge_cyc, 2 + 2 * TMO + 1);
        check_eq("timeout_synced", synced, 1'b0);
        check_eq("timeout_no_byte", bv_cnt - bv0, 0);

        // Sync, 0x00 at 559-tick cycles, 0xFF at 558-tick cycles with a glitch
        bv0 = bv_cnt;
        send_byte(SYNC, 0, -1);
        send_byte(8'h00, 2, -1);
        send_byte(8'hFF, 2, 3);
        edge_up();
        wait_q(20);
        din = 1'b0;
        check_eq("t2_byte_count", bv_cnt - bv0, 2);

        check_eq("bytes_outstanding", exp_q.size(), 0);
        check_eq("carrier_err_total", ce_cnt, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
